mc_ctrl: RTL and testbench

- Multicycle MIPS main control FSM. Drives the datapath and the 3-bit ALU operation code, and consumes the ALU zero flag; it is the initiator side of the ALU op/zero interface.
- Decodes opcode/funct from the instruction register and sequences FETCH → DECODE → execute → writeback.
- Supports a configurable memory latency, so that fetch and load states wait a fixed number of cycles.

---
 rtl/mc_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_mc_ctrl.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/mc_ctrl.sv
// Multicycle MIPS main control FSM: sequences fetch/decode/execute/writeback
// and drives datapath selects, write enables and the 3-bit ALU operation code.
module mc_ctrl #(
  parameter int MEM_LAT = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic [2:0] alu_op,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       iord,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic [1:0] pc_source,
  output logic       pc_en,
  output logic       illegal,
  output logic [3:0] state
);

  localparam int CW = $clog2(MEM_LAT) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(MEM_LAT - 1);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          cnt_done_s;
  logic          rtype_ok_s;
  logic          legal_s;
  logic [2:0]    funct_alu_s;
  logic          pc_write_s;
  logic          branch_s;

  assign cnt_done_s = (cnt_q == CNT_LAST);

  // Instruction decode: R-type funct to ALU op, and overall legality
  always_comb begin
    rtype_ok_s  = 1'b0;
    funct_alu_s = 3'b000;
    case (funct)
      6'b100000: begin rtype_ok_s = 1'b1; funct_alu_s = 3'b000; end
      6'b100010: begin rtype_ok_s = 1'b1; funct_alu_s = 3'b011; end
      6'b100100: begin rtype_ok_s = 1'b1; funct_alu_s = 3'b100; end
      6'b100101: begin rtype_ok_s = 1'b1; funct_alu_s = 3'b010; end
      6'b101010: begin rtype_ok_s = 1'b1; funct_alu_s = 3'b111; end
      default:   begin rtype_ok_s = 1'b0; funct_alu_s = 3'b000; end
    endcase
    case (opcode)
      6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010: legal_s = 1'b1;
      6'b000000: legal_s = rtype_ok_s;
      default:   legal_s = 1'b0;
    endcase
  end

  // Next-state and wait-counter logic; the counter clears on every state exit
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    case (state_q)
      S_FETCH: begin
        if (cnt_done_s) begin
          state_d = S_DECODE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DECODE: begin
        case (opcode)
          6'b100011, 6'b101011: state_d = S_MEMADR;
          6'b000000: state_d = rtype_ok_s ? S_EXEC : S_FETCH;
          6'b000100: state_d = S_BRANCH;
          6'b001000: state_d = S_ADDIEX;
          6'b000010: state_d = S_JUMP;
          default:   state_d = S_FETCH;
        endcase
      end
      S_MEMADR: state_d = (opcode == 6'b100011) ? S_MEMRD : S_MEMWR;
      S_MEMRD: begin
        if (cnt_done_s) begin
          state_d = S_MEMWB;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_EXEC:   state_d = S_ALUWB;
      S_ADDIEX: state_d = S_ADDIWB;
      S_MEMWB, S_MEMWR, S_ALUWB, S_BRANCH, S_ADDIWB, S_JUMP: state_d = S_FETCH;
      default:  state_d = S_FETCH;
    endcase
  end

  // State and counter registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Moore output decode; everything held at 0 while reset is asserted
  always_comb begin
    alu_op     = 3'b000;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    iord       = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    pc_source  = 2'b00;
    illegal    = 1'b0;
    pc_write_s = 1'b0;
    branch_s   = 1'b0;
    state      = 4'd0;
    if (!rst_n) begin
      state = 4'd0;
    end else begin
      state = state_q;
      case (state_q)
        S_FETCH: begin
          alu_src_b  = 2'b01;
          ir_write   = cnt_done_s;
          pc_write_s = cnt_done_s;
        end
        S_DECODE: begin
          alu_src_b = 2'b11;
          illegal   = ~legal_s;
        end
        S_MEMADR: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
        end
        S_MEMRD: iord = 1'b1;
        S_MEMWB: begin
          mem_to_reg = 1'b1;
          reg_write  = 1'b1;
        end
        S_MEMWR: begin
          iord      = 1'b1;
          mem_write = 1'b1;
        end
        S_EXEC: begin
          alu_src_a = 1'b1;
          alu_op    = funct_alu_s;
        end
        S_ALUWB: begin
          reg_dst   = 1'b1;
          reg_write = 1'b1;
        end
        S_BRANCH: begin
          alu_src_a = 1'b1;
          alu_op    = 3'b011;
          pc_source = 2'b01;
          branch_s  = 1'b1;
        end
        S_ADDIEX: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
        end
        S_ADDIWB: reg_write = 1'b1;
        S_JUMP: begin
          pc_source  = 2'b10;
          pc_write_s = 1'b1;
        end
        default: state = state_q;
      endcase
    end
    pc_en = pc_write_s | (branch_s & zero);
  end

endmodule

// File: tb/tb_mc_ctrl.sv
// Randomized bench for mc_ctrl: two instances (MEM_LAT 1 and 3) checked cycle
// by cycle against a per-instruction expected trace built from the ISA rules.
module tb_mc_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst1_n, rst3_n;
  logic [5:0] op1, fn1, op3, fn3;
  logic       z1, z3;

  logic [2:0] alu1, alu3;
  logic       sa1, sa3, iord1, iord3, mw1, mw3, irw1, irw3, rd1, rd3;
  logic       m2r1, m2r3, rw1, rw3, pcen1, pcen3, ill1, ill3;
  logic [1:0] sb1, sb3, ps1, ps3;
  logic [3:0] st1, st3;
  logic [19:0] pk1, pk3;

  mc_ctrl #(.MEM_LAT(1)) u_dut1 (
    .clk(clk), .rst_n(rst1_n), .opcode(op1), .funct(fn1), .zero(z1),
    .alu_op(alu1), .alu_src_a(sa1), .alu_src_b(sb1), .iord(iord1),
    .mem_write(mw1), .ir_write(irw1), .reg_dst(rd1), .mem_to_reg(m2r1),
    .reg_write(rw1), .pc_source(ps1), .pc_en(pcen1), .illegal(ill1), .state(st1)
  );

  mc_ctrl #(.MEM_LAT(3)) u_dut3 (
    .clk(clk), .rst_n(rst3_n), .opcode(op3), .funct(fn3), .zero(z3),
    .alu_op(alu3), .alu_src_a(sa3), .alu_src_b(sb3), .iord(iord3),
    .mem_write(mw3), .ir_write(irw3), .reg_dst(rd3), .mem_to_reg(m2r3),
    .reg_write(rw3), .pc_source(ps3), .pc_en(pcen3), .illegal(ill3), .state(st3)
  );

  // Packed view: state, alu_op, src_a, src_b, iord, mem_write, ir_write,
  // reg_dst, mem_to_reg, reg_write, pc_source, pc_en, illegal
  assign pk1 = {st1, alu1, sa1, sb1, iord1, mw1, irw1, rd1, m2r1, rw1, ps1, pcen1, ill1};
  assign pk3 = {st3, alu3, sa3, sb3, iord3, mw3, irw3, rd3, m2r3, rw3, ps3, pcen3, ill3};

  int n_cmp = 0;
  int n_err = 0;
  logic [19:0] exp_q[$];

  task automatic check(input string tag, input logic [19:0] obs, input logic [19:0] expv);
    n_cmp++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic logic [19:0] rec(input int st, input logic [2:0] alu, input logic sa,
                                      input logic [1:0] sb, input logic io, input logic mw,
                                      input logic irw, input logic rd, input logic m2r,
                                      input logic rw, input logic [1:0] ps, input logic pcen,
                                      input logic ill);
    return {4'(st), alu, sa, sb, io, mw, irw, rd, m2r, rw, ps, pcen, ill};
  endfunction

  function automatic logic rtype_alu(input logic [5:0] fn, output logic [2:0] alu);
    logic [5:0] fns  [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    logic [2:0] alus [5] = '{3'b000, 3'b011, 3'b100, 3'b010, 3'b111};
    alu = 3'b000;
    for (int k = 0; k < 5; k++) begin
      if (fn == fns[k]) begin
        alu = alus[k];
        return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  // Expected per-cycle trace of one instruction, from FETCH back to just before the next FETCH
  task automatic build(input int lat, input logic [5:0] op, input logic [5:0] fn, input logic z,
                       output bit writer, output bit is_sw);
    logic [2:0] ralu;
    bit lw, sw, rt, beq, addi, jmp, ill;
    exp_q.delete();
    lw   = (op == 6'b100011);
    sw   = (op == 6'b101011);
    rt   = (op == 6'b000000) && rtype_alu(fn, ralu);
    beq  = (op == 6'b000100);
    addi = (op == 6'b001000);
    jmp  = (op == 6'b000010);
    ill  = !(lw || sw || rt || beq || addi || jmp);
    writer = lw || rt || addi;
    is_sw  = sw;
    for (int c = 0; c < lat; c++)
      exp_q.push_back(rec(0, 3'b000, 1'b0, 2'b01, 1'b0, 1'b0, c == lat - 1, 1'b0, 1'b0, 1'b0,
                          2'b00, c == lat - 1, 1'b0));
    exp_q.push_back(rec(1, 3'b000, 1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, ill));
    if (lw || sw)
      exp_q.push_back(rec(2, 3'b000, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0));
    if (lw) begin
      for (int c = 0; c < lat; c++)
        exp_q.push_back(rec(3, 3'b000, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0));
      exp_q.push_back(rec(4, 3'b000, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0));
    end
    if (sw)
      exp_q.push_back(rec(5, 3'b000, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0));
    if (rt) begin
      exp_q.push_back(rec(6, ralu, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0));
      exp_q.push_back(rec(7, 3'b000, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0));
    end
    if (beq)
      exp_q.push_back(rec(8, 3'b011, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, z, 1'b0));
    if (addi) begin
      exp_q.push_back(rec(9, 3'b000, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0));
      exp_q.push_back(rec(10, 3'b000, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0));
    end
    if (jmp)
      exp_q.push_back(rec(11, 3'b000, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 1'b1, 1'b0));
  endtask

  // Run one instruction on the selected instance; rst_at > 0 aborts it with a 3-cycle reset
  task automatic run_instr(input bit s, input logic [5:0] op, input logic [5:0] fn,
                           input logic z, input int rst_at);
    bit writer, is_sw;
    int len, stop, rw_cnt, mw_cnt;
    logic [19:0] obs;
    build(s ? 3 : 1, op, fn, z, writer, is_sw);
    len    = exp_q.size();
    stop   = (rst_at > 0 && rst_at < len) ? rst_at : len;
    rw_cnt = 0;
    mw_cnt = 0;
    for (int i = 0; i < stop; i++) begin
      @(negedge clk);
      if (i == 0) begin
        if (s) begin op3 = op; fn3 = fn; z3 = z; rst3_n = 1'b1; rst1_n = 1'b0; end
        else   begin op1 = op; fn1 = fn; z1 = z; rst1_n = 1'b1; rst3_n = 1'b0; end
      end
      #1;
      obs = s ? pk3 : pk1;
      check($sformatf("lat%0d op%b fn%b cyc%0d", s ? 3 : 1, op, fn, i), obs, exp_q[i]);
      check("idle_inst_zero", s ? pk1 : pk3, 20'h0);
      rw_cnt += int'(obs[4]);
      mw_cnt += int'(obs[8]);
    end
    if (stop < len) begin
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        if (s) rst3_n = 1'b0; else rst1_n = 1'b0;
        #1;
        check("midop_reset", s ? pk3 : pk1, 20'h0);
      end
    end
    check("reg_write_pulses", 20'(rw_cnt), (writer && stop == len) ? 20'd1 : 20'd0);
    check("mem_write_pulses", 20'(mw_cnt), (is_sw && stop == len) ? 20'd1 : 20'd0);
  endtask

  initial begin
    logic [5:0] legal_fn [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    logic [5:0] op, fn;
    int r, ra;
    rst1_n = 1'b0; rst3_n = 1'b0;
    op1 = 6'd0; fn1 = 6'd0; z1 = 1'b0;
    op3 = 6'd0; fn3 = 6'd0; z3 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      check("reset_lat1", pk1, 20'h0);
      check("reset_lat3", pk3, 20'h0);
    end

    for (int k = 0; k < 5; k++) run_instr(1'b0, 6'b000000, legal_fn[k], 1'b0, 0);
    run_instr(1'b1, 6'b100011, 6'd0, 1'b0, 0);
    run_instr(1'b1, 6'b101011, 6'd0, 1'b0, 0);
    run_instr(1'b0, 6'b000100, 6'd0, 1'b1, 0);
    run_instr(1'b0, 6'b000100, 6'd0, 1'b0, 0);
    run_instr(1'b0, 6'b001000, 6'd0, 1'b0, 0);
    run_instr(1'b0, 6'b000010, 6'd0, 1'b0, 0);
    run_instr(1'b0, 6'b111111, 6'd0, 1'b0, 0);
    run_instr(1'b0, 6'b000000, 6'b000000, 1'b0, 0);
    run_instr(1'b1, 6'b100011, 6'd0, 1'b0, 6);
    run_instr(1'b1, 6'b000000, 6'b101010, 1'b1, 0);

    for (int n = 0; n < 200; n++) begin
      r  = $urandom_range(0, 9);
      fn = 6'($urandom_range(0, 63));
      case (r)
        0, 9: op = 6'b100011;
        1: op = 6'b101011;
        2, 3: begin op = 6'b000000; fn = legal_fn[$urandom_range(0, 4)]; end
        4: op = 6'b000000;
        5: op = 6'b000100;
        6: op = 6'b001000;
        7: op = 6'b000010;
        default: op = 6'($urandom_range(0, 63));
      endcase
      ra = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 9) : 0;
      run_instr(1'($urandom_range(0, 1)), op, fn, 1'($urandom_range(0, 1)), ra);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
